// File: rtl/portin_deser.sv
// Receive-side deserializer for one router port: rebuilds LSB-first serial frames into
// WIDTH-bit words and writes them to the port input FIFO. Optional parity: PORTIN_PARITY_EN.
module portin_deser #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             din,
    input  logic             frame_n,
    input  logic             valid_n,
    input  logic             fifo_full,
    output logic [WIDTH-1:0] word,
    output logic             push,
    output logic             busy,
    output logic             err_short,
    output logic             err_long,
    output logic             err_drop
);

`ifdef PORTIN_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_LEN);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_DONE    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

`ifdef PORTIN_PARITY_EN
    function automatic logic even_par(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             pend_q, pend_d;
    logic             lpend_q, lpend_d;
    logic             par_ok_q, par_ok_d;
    logic             push_q, push_d;
    logic             busy_q, busy_d;
    logic             err_short_q, err_short_d;
    logic             err_long_q, err_long_d;
    logic             err_drop_q, err_drop_d;
    logic             qual_s;

    // Next-state and output decode for the receive FSM
    always_comb begin
        qual_s      = !frame_n && !valid_n;
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        word_d      = word_q;
        pend_d      = pend_q;
        lpend_d     = lpend_q;
        par_ok_d    = par_ok_q;
        push_d      = 1'b0;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        err_drop_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (qual_s) begin
                    shreg_d = {din, {(WIDTH-1){1'b0}}};
                    cnt_d   = CNT_ONE;
                    state_d = ST_RECV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (frame_n) begin
                    err_short_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (!valid_n) begin
                    // Right shift: after WIDTH bits the first bit sits at word[0]
`ifdef PORTIN_PARITY_EN
                    if (cnt_q == CW'(WIDTH)) begin
                        par_ok_d = (din == even_par(shreg_q));
                    end else begin
                        shreg_d = {din, shreg_q[WIDTH-1:1]};
                    end
`else
                    shreg_d = {din, shreg_q[WIDTH-1:1]};
`endif
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = CNT_FULL;
                        pend_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_DONE: begin
                if (pend_q) begin
                    pend_d = 1'b0;
                    if (!par_ok_q) begin
                        err_short_d = 1'b1;
                    end else if (fifo_full) begin
                        err_drop_d = 1'b1;
                    end else begin
                        push_d = 1'b1;
                        word_d = shreg_q;
                    end
                    // An extra bit colliding with the push cycle is flagged one cycle later
                    if (frame_n) begin
                        state_d = ST_IDLE;
                    end else if (!valid_n) begin
                        lpend_d = 1'b1;
                        state_d = ST_DISCARD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (frame_n) begin
                    state_d = ST_IDLE;
                end else if (!valid_n) begin
                    err_long_d = 1'b1;
                    state_d    = ST_DISCARD;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DISCARD: begin
                if (lpend_q) begin
                    err_long_d = 1'b1;
                    lpend_d    = 1'b0;
                end else begin
                    lpend_d = 1'b0;
                end
                if (frame_n) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DISCARD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_d;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            word_q      <= '0;
            pend_q      <= 1'b0;
            lpend_q     <= 1'b0;
            par_ok_q    <= 1'b1;
            push_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            err_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            word_q      <= word_d;
            pend_q      <= pend_d;
            lpend_q     <= lpend_d;
            par_ok_q    <= par_ok_d;
            push_q      <= push_d;
            busy_q      <= busy_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            err_drop_q  <= err_drop_d;
        end
    end

    assign word      = word_q;
    assign push      = push_q;
    assign busy      = busy_q;
    assign err_short = err_short_q;
    assign err_long  = err_long_q;
    assign err_drop  = err_drop_q;

endmodule

// File: tb/tb_portin_deser.sv
// Directed bench for portin_deser (WIDTH=32); follows PORTIN_PARITY_EN if defined.
module tb_portin_deser;

    logic        clock;
    logic        reset_n;
    logic        din;
    logic        frame_n;
    logic        valid_n;
    logic        fifo_full;
    logic [31:0] word;
    logic        push;
    logic        busy;
    logic        err_short;
    logic        err_long;
    logic        err_drop;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int push_cnt   = 0;
    int short_cnt  = 0;
    int long_cnt   = 0;
    int drop_cnt   = 0;
    int excl_cnt   = 0;
    logic [31:0] pushed [0:15];

    portin_deser #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .din       (din),
        .frame_n   (frame_n),
        .valid_n   (valid_n),
        .fifo_full (fifo_full),
        .word      (word),
        .push      (push),
        .busy      (busy),
        .err_short (err_short),
        .err_long  (err_long),
        .err_drop  (err_drop)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse monitor, sampled on the inactive edge
    always @(negedge clock) begin
        if (reset_n) begin
            if (push) begin
                if (push_cnt < 16) pushed[push_cnt] = word;
                push_cnt = push_cnt + 1;
            end
            if (err_short) short_cnt = short_cnt + 1;
            if (err_long)  long_cnt  = long_cnt + 1;
            if (err_drop)  drop_cnt  = drop_cnt + 1;
            if ((32'(push) + 32'(err_short) + 32'(err_long) + 32'(err_drop)) > 32'd1)
                excl_cnt = excl_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt = checks_cnt + 1;
        if (got !== exp) begin
            errors_cnt = errors_cnt + 1;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive n data bits LSB first; 3 stall cycles (din toggled) after bit indices s1/s2
    task automatic send_bits(input logic [31:0] w, input int n, input int s1, input int s2);
        for (int i = 0; i < n; i++) begin
            din = w[i]; frame_n = 1'b0; valid_n = 1'b0;
            @(negedge clock);
            if (i == s1 || i == s2) begin
                valid_n = 1'b1; din = ~din;
                repeat (3) @(negedge clock);
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int s1, input int s2, input logic bad);
        send_bits(w, 32, s1, s2);
`ifdef PORTIN_PARITY_EN
        din = (^w) ^ bad; frame_n = 1'b0; valid_n = 1'b0;
        @(negedge clock);
`endif
    endtask

    task automatic end_frame();
        frame_n = 1'b1; valid_n = 1'b1; din = 1'b0;
    endtask

    int p0, s0, l0, d0;

    initial begin
        reset_n = 1'b0; din = 1'b0; frame_n = 1'b1; valid_n = 1'b1; fifo_full = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_word", word, 32'h0);
        chk("rst_push", 32'(push), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_errs", {29'h0, err_short, err_long, err_drop}, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // 1: plain frame, latency and busy
        send_word(32'hA5A5_0F0F, -1, -1, 1'b0);
        chk("t1_push_lat0", 32'(push), 32'h0);
        chk("t1_busy_mid", 32'(busy), 32'h1);
        end_frame();
        @(negedge clock);
        chk("t1_push_lat1", 32'(push), 32'h1);
        chk("t1_word", word, 32'hA5A5_0F0F);
        chk("t1_busy_end", 32'(busy), 32'h0);
        @(negedge clock);
        chk("t1_push_1cyc", 32'(push), 32'h0);

        // 2: stalls after bits 7 and 20
        p0 = push_cnt;
        send_word(32'h1234_5678, 7, 20, 1'b0);
        end_frame();
        repeat (3) @(negedge clock);
        chk("t2_push_cnt", 32'(push_cnt - p0), 32'd1);
        chk("t2_word", word, 32'h1234_5678);

        // 3: short frame, then immediate good frame
        p0 = push_cnt; s0 = short_cnt;
        send_bits(32'hFFFF_FFFF, 17, -1, -1);
        end_frame();
        @(negedge clock);
        chk("t3_err_short", 32'(err_short), 32'h1);
        chk("t3_no_push", 32'(push), 32'h0);
        send_word(32'hDEAD_BEEF, -1, -1, 1'b0);
        end_frame();
        repeat (3) @(negedge clock);
        chk("t3_short_cnt", 32'(short_cnt - s0), 32'd1);
        chk("t3_push_cnt", 32'(push_cnt - p0), 32'd1);
        chk("t3_word", word, 32'hDEAD_BEEF);

        // 4: fifo full drop, then extra bits give one err_long
        p0 = push_cnt; l0 = long_cnt; d0 = drop_cnt;
        fifo_full = 1'b1;
        send_word(32'hCAFE_F00D, -1, -1, 1'b0);
        send_bits(32'h0000_0005, 3, -1, -1);
        end_frame();
        repeat (3) @(negedge clock);
        fifo_full = 1'b0;
        chk("t4_drop_cnt", 32'(drop_cnt - d0), 32'd1);
        chk("t4_push_cnt", 32'(push_cnt - p0), 32'd0);
        chk("t4_long_cnt", 32'(long_cnt - l0), 32'd1);
        chk("t4_word_hold", word, 32'hDEAD_BEEF);

        // 5: back-to-back frames with a 1-cycle gap
        p0 = push_cnt;
        send_word(32'h0000_0001, -1, -1, 1'b0);
        end_frame();
        @(negedge clock);
        send_word(32'h8000_0000, -1, -1, 1'b0);
        end_frame();
        repeat (3) @(negedge clock);
        chk("t5_push_cnt", 32'(push_cnt - p0), 32'd2);
        if (push_cnt - p0 == 2 && p0 < 15) begin
            chk("t5_word0", pushed[p0], 32'h0000_0001);
            chk("t5_word1", pushed[p0+1], 32'h8000_0000);
        end

        // 6: reset mid-frame, then all-ones frame
        p0 = push_cnt;
        send_bits(32'hFFFF_FFFF, 12, -1, -1);
        #2 reset_n = 1'b0;
        end_frame();
        #1;
        chk("t6_rst_word", word, 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'h0);
        chk("t6_rst_push", 32'(push), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        send_word(32'hFFFF_FFFF, -1, -1, 1'b0);
        end_frame();
        repeat (3) @(negedge clock);
        chk("t6_push_cnt", 32'(push_cnt - p0), 32'd1);
        chk("t6_word", word, 32'hFFFF_FFFF);
`ifdef PORTIN_PARITY_EN
        p0 = push_cnt; s0 = short_cnt;
        send_word(32'h0000_0003, -1, -1, 1'b1);
        end_frame();
        repeat (3) @(negedge clock);
        chk("t6_par_short", 32'(short_cnt - s0), 32'd1);
        chk("t6_par_nopush", 32'(push_cnt - p0), 32'd0);
`endif

        chk("exclusive_pulses", 32'(excl_cnt), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
